// File: rtl/mux_seq_pkg.sv
// Shared types for the mux select sequencer: FSM states, channel index type
// and a lowest-set-bit helper used when a scan starts.
package mux_seq_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } seq_state_t;

  function automatic ch_idx_t lowest_set(input logic [NUM_CH-1:0] m);
    ch_idx_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = ch_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Wrap-around priority search: first set mask bit after cur. wrapped flags
// that the search went past channel D (or found only cur itself).
module mux_next_ch
  import mux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  ch_idx_t           cur,
  output ch_idx_t           next,
  output logic              wrapped
);

  ch_idx_t cand;
  logic    found;

  always_comb begin
    next  = cur;
    cand  = cur;
    found = 1'b0;
    // i == NUM_CH lands back on cur, covering the single-channel mask
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = cur + ch_idx_t'(i);
      if (!found && mask[cand]) begin
        next  = cand;
        found = 1'b1;
      end
    end
    wrapped = (next <= cur);
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scans the 4:1 mux channels in mask order, settles, then samples mux_y.
// Define MUX_SEQ_SWEEP_CNT_EN to add the saturating sweep_count output.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              mux_y,
  output logic              sel_1,
  output logic              sel_2,
  output ch_idx_t           ch_idx,
  output logic              ch_valid,
  output logic [NUM_CH-1:0] sample,
  output logic              busy,
  output logic              sweep_done,
`ifdef MUX_SEQ_SWEEP_CNT_EN
  output logic [7:0]        sweep_count,
`endif
  output seq_state_t        state_dbg
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  ch_idx_t           ch_idx_n;
  logic [NUM_CH-1:0] mask_q, mask_n;
  logic              cont_q, cont_n;
  logic              done_n;
  logic              accept;
  ch_idx_t           next_ch;
  logic              wrapped;

  mux_next_ch u_next_ch (
    .mask    (mask_q),
    .cur     (ch_idx),
    .next    (next_ch),
    .wrapped (wrapped)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ch_idx_n = ch_idx;
    mask_n   = mask_q;
    cont_n   = cont_q;
    done_n   = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop && (ch_mask != '0)) begin
          accept   = 1'b1;
          mask_n   = ch_mask;
          cont_n   = continuous;
          ch_idx_n = lowest_set(ch_mask);
          cnt_n    = RELOAD;
          state_n  = SETTLE;
        end
      end
      SETTLE: begin
        if (stop)             state_n = IDLE;
        else if (cnt == '0)   state_n = SAMPLE;
        else                  cnt_n   = cnt - CNT_W'(1);
      end
      SAMPLE: begin
        if (stop) begin
          state_n = IDLE;
        end else begin
          done_n = wrapped;
          if (wrapped && !cont_q) begin
            state_n = IDLE;
          end else begin
            ch_idx_n = next_ch;
            cnt_n    = RELOAD;
            state_n  = SETTLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ch_valid/busy are registered views of the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ch_idx     <= '0;
      mask_q     <= '0;
      cont_q     <= 1'b0;
      sample     <= '0;
      ch_valid   <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ch_idx     <= ch_idx_n;
      mask_q     <= mask_n;
      cont_q     <= cont_n;
      ch_valid   <= (state_n == SAMPLE);
      busy       <= (state_n != IDLE);
      sweep_done <= done_n;
      if (state == SAMPLE) sample[ch_idx] <= mux_y;
    end
  end

`ifdef MUX_SEQ_SWEEP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             sweep_count <= '0;
    else if (accept)                       sweep_count <= '0;
    else if (done_n && sweep_count != 8'hFF) sweep_count <= sweep_count + 8'd1;
  end
`endif

  assign sel_1     = ch_idx[0];
  assign sel_2     = ch_idx[1];
  assign state_dbg = state;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer: directed scenarios plus random
// traffic, checked every cycle against a time-based scan model.
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;

  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 1;

  logic       clk, reset, start, stop, continuous, mux_y;
  logic [3:0] ch_mask, sample, mux_data;
  logic       sel_1, sel_2, ch_valid, busy, sweep_done;
  ch_idx_t    ch_idx;
  seq_state_t state_dbg;
`ifdef MUX_SEQ_SWEEP_CNT_EN
  logic [7:0] sweep_count;
`endif

  mux_sel_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .mux_y      (mux_y),
    .sel_1      (sel_1),
    .sel_2      (sel_2),
    .ch_idx     (ch_idx),
    .ch_valid   (ch_valid),
    .sample     (sample),
    .busy       (busy),
    .sweep_done (sweep_done),
`ifdef MUX_SEQ_SWEEP_CNT_EN
    .sweep_count(sweep_count),
`endif
    .state_dbg  (state_dbg)
  );

  // downstream 4:1 mux model
  assign mux_y = mux_data[{sel_2, sel_1}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the scan is derived from elapsed cycles
  bit         m_active, m_cont;
  int         m_t, m_n;
  logic [1:0] m_list[4];
  logic [1:0] exp_ch;
  logic [3:0] exp_sample;
  logic       exp_done;
  int         exp_cnt;
  logic [1:0] exp_q[$];

  function automatic logic exp_valid();
    return m_active && ((m_t - 1) % P == P - 1);
  endfunction

  task automatic model_reset();
    m_active = 0; m_cont = 0; m_t = 0; m_n = 0;
    exp_ch = 2'd0; exp_sample = 4'd0; exp_done = 1'b0; exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic ct, input logic [3:0] m);
    if (exp_valid()) exp_sample[exp_ch] = mux_data[exp_ch];
    exp_done = 1'b0;
    if (!m_active) begin
      if (st && !sp && m != 4'd0) begin
        m_active = 1; m_cont = ct; m_t = 1; m_n = 0; exp_cnt = 0;
        for (int i = 0; i < 4; i++) if (m[i]) begin m_list[m_n] = 2'(i); m_n++; end
      end
    end else if (sp) begin
      m_active = 0;
    end else begin
      m_t++;
      if ((m_t - 1) % P == 0 && ((m_t - 1) / P) % m_n == 0) exp_done = 1'b1;
      if (exp_done && !m_cont) m_active = 0;
      if (exp_done && exp_cnt < 255) exp_cnt++;
    end
    if (m_active) exp_ch = m_list[((m_t - 1) / P) % m_n];
    if (exp_valid()) exp_q.push_back(exp_ch);
  endtask

  task automatic check_all();
    check("ch_valid",   ch_valid,   exp_valid());
    check("busy",       busy,       m_active);
    check("sweep_done", sweep_done, exp_done);
    check("ch_idx",     ch_idx,     exp_ch);
    check("sel_1",      sel_1,      exp_ch[0]);
    check("sel_2",      sel_2,      exp_ch[1]);
    check("sample",     sample,     exp_sample);
    check("state",      state_dbg != IDLE, m_active);
`ifdef MUX_SEQ_SWEEP_CNT_EN
    check("sweep_count", sweep_count, exp_cnt);
`endif
    if (ch_valid) begin
      if (exp_q.size() > 0) check("sb_ch", ch_idx, exp_q.pop_front());
      else                  check("sb_extra", ch_valid, 1'b0);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic ct, input logic [3:0] m);
    start = st; stop = sp; continuous = ct; ch_mask = m;
    @(posedge clk);
    model_edge(st, sp, ct, m);
    #1 check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; continuous = 0; ch_mask = 4'd0;
    mux_data = 4'b1101;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    #2 reset = 1'b0;

    // single sweep, all channels, A..D = 1,0,1,1
    step(1'b1, 1'b0, 1'b0, 4'b1111);
    idle_steps(14);
    check("sweep_sample", sample, 4'b1101);

    // sparse mask, continuous: sel_1 must stay high
    mux_data = 4'b0110;
    step(1'b1, 1'b0, 1'b1, 4'b1010);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0);
      check("sparse_sel_1", sel_1, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 4'd0);
    idle_steps(2);

    // zero mask start is ignored
    step(1'b1, 1'b0, 1'b1, 4'd0);
    idle_steps(4);

    // abort during channel 2 settle
    mux_data = 4'b0011;
    step(1'b1, 1'b0, 1'b0, 4'b1111);
    idle_steps(6);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    idle_steps(3);

    // start+stop together in IDLE, then start/mask changes mid-scan
    step(1'b1, 1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 1'b0, 4'b0011);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 4'b1100);
    idle_steps(4);

    // async reset mid-SETTLE
    step(1'b1, 1'b0, 1'b1, 4'b0110);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("rst_busy",   busy,   1'b0);
    check("rst_ch_idx", ch_idx, 2'd0);
    check("rst_state",  state_dbg, IDLE);
    #1 reset = 1'b0;
    idle_steps(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) mux_data = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b1, 1'b0, 4'd0);
    idle_steps(2);
    check("sb_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the 4:1 select mux; generates sel_1/sel_2 to scan channels A..D in order.
- Waits a programmable settle time per channel, then captures the mux output into a per-channel sample register.
- Supports single-sweep and continuous scan over a latched channel mask.
- Sits between the board-level control (switches/buttons) and the mux; also consumes the mux output Y.

Parameters:
- SETTLE_CYCLES, 2, cycles held on a channel before sampling; legal range 1..255
- CNT_W, 8, width of the settle down-counter; must satisfy SETTLE_CYCLES <= 2**CNT_W-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin scan; honoured only in IDLE
- stop  input  1  abort scan; returns to IDLE
- continuous  input  1  0 = single sweep, 1 = repeat; sampled with start
- ch_mask  input  4  channel enable (bit0=A ... bit3=D); sampled with start
- mux_y  input  1  output of the downstream 4:1 mux
- sel_1  output  1  mux select LSB (A/B and C/D pair select)
- sel_2  output  1  mux select MSB (pair select)
- ch_idx  output  2  current channel, {sel_2, sel_1}
- ch_valid  output  1  one-cycle pulse: mux_y sampled this cycle
- sample  output  4  captured value per channel
- busy  output  1  high in any state other than IDLE
- sweep_done  output  1  one-cycle pulse at the end of each full sweep

Behaviour:
- Reset (async, active-high): state=IDLE; sel_1=0, sel_2=0, ch_idx=0, ch_valid=0, busy=0, sweep_done=0, sample=4'b0000; latched mask and mode are cleared.
- The states are IDLE, SETTLE and SAMPLE. Outputs are registered. sel_1 = ch_idx[0] and sel_2 = ch_idx[1] at all times.
- IDLE, with start=1, stop=0 and ch_mask!=0:
  - latch mask and continuous;
  - ch_idx <= lowest set bit of ch_mask;
  - counter <= SETTLE_CYCLES-1;
  - move to SETTLE.
- IDLE, with start=1 and ch_mask=0: ignored; stays in IDLE with no pulses.
- SETTLE: the counter decrements each cycle. When it reaches 0, move to SAMPLE.
- SAMPLE (exactly one cycle):
  - ch_valid=1;
  - sample[ch_idx] <= mux_y at the closing edge;
  - compute next = first set latched-mask bit after ch_idx, with wrap-around.
  - If next <= ch_idx (the sweep wrapped, including the single-bit mask case), pulse sweep_done in the following cycle. Single mode then goes to IDLE; continuous mode continues.
  - Otherwise, or in continuous mode: ch_idx <= next, counter reloads, move to SETTLE.
- Latency: first ch_valid is SETTLE_CYCLES+1 cycles after the start edge. Per-channel period is SETTLE_CYCLES+1 cycles.
- stop=1 in SETTLE or SAMPLE: go to IDLE next cycle.
  - If the abort lands on the SAMPLE cycle, ch_valid still pulses and sample still updates on that edge.
  - No sweep_done. sample and ch_idx hold their values.
  - stop has priority over start.
- start while busy: ignored. ch_mask and continuous changes mid-scan: ignored until the next start.
- Reset mid-scan: immediate return to the reset values above.

Optional Feature:
- MUX_SEQ_SWEEP_CNT_EN defined:
  - adds output sweep_count, 8 bits, reset 0;
  - increments on each sweep_done and saturates at 255;
  - cleared on each accepted start.
- MUX_SEQ_SWEEP_CNT_EN undefined: the port and its logic are absent.

Decomposition:
- Package mux_seq_pkg:
  - state typedef seq_state_t {IDLE, SETTLE, SAMPLE};
  - NUM_CH=4;
  - ch_idx_t (logic [1:0]).
- Sub-module mux_next_ch: purely combinational wrap-around priority search.
  - Inputs: mask, cur.
  - Outputs: next, wrapped.
  - Instantiated once.

Test Plan:
- Reset mid-SETTLE:
  - assert reset asynchronously -> all outputs 0 immediately, state IDLE.
- Single sweep, all channels:
  - settings: SETTLE_CYCLES=2, ch_mask=4'b1111, continuous=0, mux_y driven by a model with A..D=1,0,1,1; start pulse at cycle 0;
  - ch_valid at cycles 3, 6, 9, 12 with ch_idx 0, 1, 2, 3;
  - sweep_done at cycle 13, busy low from cycle 13;
  - sample=4'b1101.
- Sparse mask:
  - settings: ch_mask=4'b1010, continuous=1;
  - ch_idx sequence is 1, 3, 1, 3...;
  - sweep_done pulses after each ch_idx=3 sample;
  - sel_1 stays 1 throughout.
- Zero mask:
  - start with ch_mask=0 -> busy stays 0, no ch_valid, no sweep_done.
- Abort:
  - stop asserted during channel 2 SETTLE -> IDLE next cycle;
  - no sweep_done;
  - sample bits 0..1 keep their captured values, bits 2..3 unchanged.
- Simultaneous events:
  - start and stop together in IDLE -> stays IDLE;
  - start during busy -> ignored;
  - ch_mask change mid-scan -> no effect on the channel sequence.
